// File: rtl/oct_scan_pkg.sv
// Shared types for the OCT scan sequencer: FSM state encoding, shadow config record, config validity check.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package oct_scan_pkg;

   localparam int CNT_W_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // One scan's worth of geometry and strobe timing, as loaded from the frame decoder.
   typedef struct packed {
      logic [CNT_W_DEF-1:0] x_points;
      logic [CNT_W_DEF-1:0] x_blocks;
      logic [CNT_W_DEF-1:0] y_points;
      logic [CNT_W_DEF-1:0] cycles_per_point;
      logic [CNT_W_DEF-1:0] da_delay;
      logic [CNT_W_DEF-1:0] acq_delay;
      logic [CNT_W_DEF-1:0] ccd_delay;
   } cfg_t;

   // A scan is runnable only with non-empty geometry and every strobe landing inside the point.
   function automatic logic cfg_ok(input cfg_t c);
      return (c.x_points != '0) && (c.x_blocks != '0) && (c.y_points != '0) &&
             (c.cycles_per_point != '0) &&
             (c.da_delay  < c.cycles_per_point) &&
             (c.acq_delay < c.cycles_per_point) &&
             (c.ccd_delay < c.cycles_per_point);
   endfunction

endpackage

// File: rtl/oct_scan_sequencer_if.sv
// Bundle between host/config side and the scan sequencer: config load, start/abort control, status and strobes.
// Latency: n/a (wiring only).
// Backpressure: none; every signal is a pulse or level, no handshake.
interface oct_scan_if
   import oct_scan_pkg::*;
   #(parameter int CNT_W = CNT_W_DEF);

   logic             cfg_valid;
   logic [CNT_W-1:0] x_points;
   logic [CNT_W-1:0] x_blocks;
   logic [CNT_W-1:0] y_points;
   logic [CNT_W-1:0] cycles_per_point;
   logic [CNT_W-1:0] da_delay;
   logic [CNT_W-1:0] acq_delay;
   logic [CNT_W-1:0] ccd_delay;
   logic             start;
   logic             abort;
   logic             busy;
   logic [CNT_W-1:0] x_idx;
   logic [CNT_W-1:0] blk_idx;
   logic [CNT_W-1:0] y_idx;
   logic             da_strobe;
   logic             acq_trig;
   logic             ccd_trig;
   logic             line_done;
   logic             scan_done;
   logic             cfg_err;

   modport master (
      output cfg_valid, x_points, x_blocks, y_points, cycles_per_point,
             da_delay, acq_delay, ccd_delay, start, abort,
      input  busy, x_idx, blk_idx, y_idx, da_strobe, acq_trig, ccd_trig,
             line_done, scan_done, cfg_err
   );

   modport slave (
      input  cfg_valid, x_points, x_blocks, y_points, cycles_per_point,
             da_delay, acq_delay, ccd_delay, start, abort,
      output busy, x_idx, blk_idx, y_idx, da_strobe, acq_trig, ccd_trig,
             line_done, scan_done, cfg_err
   );

endinterface

// File: rtl/point_timer.sv
// Per-point cycle counter with registered DA/ACQ/CCD compare strobes and last-cycle flags.
// Latency: strobes are registered from the next-cycle counter value, so they line up with the counter itself.
// Backpressure: none; counts whenever the sequencer is in RUN.
// Ports: run_q/run_d = current/next RUN state; period and delays = active config;
//        last_cycle = registered "this cycle is c==P-1"; last_next = same flag for the coming cycle.
module point_timer
   import oct_scan_pkg::*;
   #(parameter int CNT_W = CNT_W_DEF)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run_q,
   input  logic             run_d,
   input  logic [CNT_W-1:0] period,
   input  logic [CNT_W-1:0] da_delay,
   input  logic [CNT_W-1:0] acq_delay,
   input  logic [CNT_W-1:0] ccd_delay,
   output logic             da_strobe,
   output logic             acq_trig,
   output logic             ccd_trig,
   output logic             last_cycle,
   output logic             last_next
);

   logic [CNT_W-1:0] c_q, c_d, last_c;
   logic             da_q, da_d, acq_q, acq_d, ccd_q, ccd_d, last_q;

   always_comb begin
      last_c = period - CNT_W'(1);
      c_d    = '0;
      // First RUN cycle (run_q low) and point wrap both land on c=0.
      if (run_q && run_d && (c_q != last_c)) begin
         c_d = c_q + CNT_W'(1);
      end
      da_d      = run_d && (c_d == da_delay);
      acq_d     = run_d && (c_d == acq_delay);
      ccd_d     = run_d && (c_d == ccd_delay);
      last_next = run_d && (c_d == last_c);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_q    <= '0;
         da_q   <= 1'b0;
         acq_q  <= 1'b0;
         ccd_q  <= 1'b0;
         last_q <= 1'b0;
      end else begin
         c_q    <= c_d;
         da_q   <= da_d;
         acq_q  <= acq_d;
         ccd_q  <= ccd_d;
         last_q <= last_next;
      end
   end

   assign da_strobe  = da_q;
   assign acq_trig   = acq_q;
   assign ccd_trig   = ccd_q;
   assign last_cycle = last_q;

endmodule

// File: rtl/oct_scan_sequencer.sv
// OCT scan sequencer: walks every (x, block, y) point at P cycles per point and emits per-point trigger strobes.
// Latency: start sampled at T -> busy and point (0,0,0) c=0 at T+1; all outputs registered.
// Backpressure: none; abort (level) forces IDLE on the next cycle, start outside IDLE is ignored.
// Ports: clk, rst_n (async active-low), bus = oct_scan_if.slave carrying config, start/abort, status, indices, strobes.
module oct_scan_sequencer
   import oct_scan_pkg::*;
   #(parameter int CNT_W = CNT_W_DEF)
(
   input  logic   clk,
   input  logic   rst_n,
   oct_scan_if.slave bus
);

   state_t           state_q, state_d;
   cfg_t             cfg_q, cfg_d;     // shadow config, loaded by cfg_valid in IDLE
   cfg_t             act_q, act_d;     // config of the scan in flight, copied from shadow on start
   cfg_t             cfg_in;
   logic [CNT_W-1:0] x_q, x_d, blk_q, blk_d, y_q, y_d;
   logic             busy_q, busy_d, line_done_q, line_done_d;
   logic             scan_done_q, scan_done_d, cfg_err_q, cfg_err_d;
   logic             run_q, run_d, last_cycle, last_next;
   logic             x_last, blk_last, y_last;

   always_comb begin
      cfg_in = '{x_points:         bus.x_points,
                 x_blocks:         bus.x_blocks,
                 y_points:         bus.y_points,
                 cycles_per_point: bus.cycles_per_point,
                 da_delay:         bus.da_delay,
                 acq_delay:        bus.acq_delay,
                 ccd_delay:        bus.ccd_delay};
   end

   assign x_last   = (x_q   == act_q.x_points - CNT_W'(1));
   assign blk_last = (blk_q == act_q.x_blocks - CNT_W'(1));
   assign y_last   = (y_q   == act_q.y_points - CNT_W'(1));

   always_comb begin
      state_d   = state_q;
      cfg_d     = cfg_q;
      act_d     = act_q;
      x_d       = x_q;
      blk_d     = blk_q;
      y_d       = y_q;
      cfg_err_d = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.cfg_valid) cfg_d = cfg_in;
            // Validated against the shadow as it stood before any same-cycle load.
            if (bus.start) begin
               if (cfg_ok(cfg_q)) begin
                  state_d = ST_RUN;
                  act_d   = cfg_q;
               end else begin
                  cfg_err_d = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (last_cycle) begin
               if (!x_last) begin
                  x_d = x_q + CNT_W'(1);
               end else begin
                  x_d = '0;
                  if (!blk_last) begin
                     blk_d = blk_q + CNT_W'(1);
                  end else begin
                     blk_d = '0;
                     if (!y_last) begin
                        y_d = y_q + CNT_W'(1);
                     end else begin
                        y_d     = '0;
                        state_d = ST_DONE;
                     end
                  end
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (bus.abort) begin
         state_d   = ST_IDLE;
         x_d       = '0;
         blk_d     = '0;
         y_d       = '0;
         cfg_err_d = 1'b0;
      end
      run_q       = (state_q == ST_RUN);
      run_d       = (state_d == ST_RUN);
      busy_d      = run_d;
      scan_done_d = (state_d == ST_DONE);
      line_done_d = last_next && (x_d == act_d.x_points - CNT_W'(1));
   end

   point_timer #(.CNT_W(CNT_W)) u_point_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .run_q      (run_q),
      .run_d      (run_d),
      .period     (act_d.cycles_per_point),
      .da_delay   (act_d.da_delay),
      .acq_delay  (act_d.acq_delay),
      .ccd_delay  (act_d.ccd_delay),
      .da_strobe  (bus.da_strobe),
      .acq_trig   (bus.acq_trig),
      .ccd_trig   (bus.ccd_trig),
      .last_cycle (last_cycle),
      .last_next  (last_next)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cfg_q       <= '0;
         act_q       <= '0;
         x_q         <= '0;
         blk_q       <= '0;
         y_q         <= '0;
         busy_q      <= 1'b0;
         line_done_q <= 1'b0;
         scan_done_q <= 1'b0;
         cfg_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cfg_q       <= cfg_d;
         act_q       <= act_d;
         x_q         <= x_d;
         blk_q       <= blk_d;
         y_q         <= y_d;
         busy_q      <= busy_d;
         line_done_q <= line_done_d;
         scan_done_q <= scan_done_d;
         cfg_err_q   <= cfg_err_d;
      end
   end

   assign bus.busy      = busy_q;
   assign bus.x_idx     = x_q;
   assign bus.blk_idx   = blk_q;
   assign bus.y_idx     = y_q;
   assign bus.line_done = line_done_q;
   assign bus.scan_done = scan_done_q;
   assign bus.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_oct_scan_sequencer.sv
// Directed bench for oct_scan_sequencer: cycle-by-cycle comparison of strobes/indices against an arithmetic
// point model, plus hand-computed pulse positions for the documented scans.
module tb_oct_scan_sequencer;
   import oct_scan_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   oct_scan_if #(.CNT_W(16)) bus ();

   oct_scan_sequencer #(.CNT_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   localparam logic [63:0] ERR_ONLY  = 64'h0001_0000_0000_0000;
   localparam logic [63:0] BUSY_ONLY = 64'h0040_0000_0000_0000;

   int   n_checks = 0;
   int   n_errors = 0;
   int   ld_seen[$];
   int   done_seen;
   cfg_t cfg_a, cfg_b, cfg_bad, cfg_p20, cfg_p1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // {busy, da, acq, ccd, line_done, scan_done, cfg_err, x, blk, y}
   function automatic logic [63:0] obs();
      return {9'b0, bus.busy, bus.da_strobe, bus.acq_trig, bus.ccd_trig, bus.line_done,
              bus.scan_done, bus.cfg_err, bus.x_idx, bus.blk_idx, bus.y_idx};
   endfunction

   // Expected outputs in cycle k after start (k=1 is the first RUN cycle), from point arithmetic.
   function automatic logic [63:0] model(input cfg_t c, input int k, input int abort_at);
      int p, xp, xb, yp, total, pt, cc, xi, bi, yi;
      p  = int'(c.cycles_per_point);
      xp = int'(c.x_points);
      xb = int'(c.x_blocks);
      yp = int'(c.y_points);
      total = xp * xb * yp * p;
      if (abort_at > 0 && k > abort_at) return 64'h0;
      if (k == total + 1) return 64'h0002_0000_0000_0000;
      if (k > total) return 64'h0;
      cc = (k - 1) % p;
      pt = (k - 1) / p;
      xi = pt % xp;
      bi = (pt / xp) % xb;
      yi = pt / (xp * xb);
      return {9'b0, 1'b1, cc == int'(c.da_delay), cc == int'(c.acq_delay), cc == int'(c.ccd_delay),
              (cc == p - 1) && (xi == xp - 1), 1'b0, 1'b0, 16'(xi), 16'(bi), 16'(yi)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_fields(input cfg_t c);
      bus.x_points         = c.x_points;
      bus.x_blocks         = c.x_blocks;
      bus.y_points         = c.y_points;
      bus.cycles_per_point = c.cycles_per_point;
      bus.da_delay         = c.da_delay;
      bus.acq_delay        = c.acq_delay;
      bus.ccd_delay        = c.ccd_delay;
   endtask

   task automatic set_cfg(input cfg_t c);
      drive_fields(c);
      bus.cfg_valid = 1'b1;
      tick();
      bus.cfg_valid = 1'b0;
   endtask

   // Pulse start and compare every cycle through DONE and one idle cycle after.
   task automatic run_scan(input string name, input cfg_t mdl, input cfg_t alt, input bit alt_with_start,
                           input int alt_at, input bit start_in_done, input int abort_at);
      int total;
      logic [63:0] o;
      total = int'(mdl.x_points) * int'(mdl.x_blocks) * int'(mdl.y_points) * int'(mdl.cycles_per_point);
      ld_seen.delete();
      done_seen = 0;
      if (alt_with_start) begin
         drive_fields(alt);
         bus.cfg_valid = 1'b1;
      end
      bus.start = 1'b1;
      tick();
      for (int k = 1; k <= total + 2; k++) begin
         o = obs();
         check($sformatf("%s k=%0d", name, k), o, model(mdl, k, abort_at));
         if (bus.line_done) ld_seen.push_back(k);
         if (bus.scan_done && done_seen == 0) done_seen = k;
         bus.cfg_valid = (k == alt_at);
         if (k == alt_at) drive_fields(alt);
         bus.abort = (abort_at > 0) && (k >= abort_at) && (k <= abort_at + 2);
         bus.start = ((abort_at > 0) && (k == abort_at + 1)) || (start_in_done && (k == total + 1));
         tick();
      end
      bus.cfg_valid = 1'b0;
      bus.abort     = 1'b0;
      bus.start     = 1'b0;
   endtask

   task automatic expect_reject(input string name);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check({name, " err pulse"}, obs(), ERR_ONLY);
      tick();
      check({name, " err clears"}, obs(), 64'h0);
   endtask

   initial begin
      cfg_a   = '{x_points:16'd3, x_blocks:16'd1, y_points:16'd2, cycles_per_point:16'd10,
                  da_delay:16'd0, acq_delay:16'd4, ccd_delay:16'd7};
      cfg_b   = '{x_points:16'd2, x_blocks:16'd3, y_points:16'd1, cycles_per_point:16'd4,
                  da_delay:16'd1, acq_delay:16'd2, ccd_delay:16'd3};
      cfg_bad = cfg_a;
      cfg_bad.acq_delay = 16'd10;
      cfg_p20 = cfg_a;
      cfg_p20.cycles_per_point = 16'd20;
      cfg_p1  = '{x_points:16'd4, x_blocks:16'd1, y_points:16'd1, cycles_per_point:16'd1,
                  da_delay:16'd0, acq_delay:16'd0, ccd_delay:16'd0};
      bus.cfg_valid = 1'b0;
      bus.start     = 1'b0;
      bus.abort     = 1'b0;
      drive_fields('0);

      repeat (2) tick();
      check("reset outputs", obs(), 64'h0);
      rst_n = 1'b1;
      tick();
      check("idle after reset", obs(), 64'h0);

      expect_reject("no config");

      set_cfg(cfg_a);
      run_scan("A", cfg_a, cfg_a, 1'b0, 0, 1'b1, 0);
      check("A scan_done cycle", 64'(done_seen), 64'd61);
      check("A line_done count", 64'(ld_seen.size()), 64'd2);
      if (ld_seen.size() == 2) begin
         check("A line_done 1st", 64'(ld_seen[0]), 64'd30);
         check("A line_done 2nd", 64'(ld_seen[1]), 64'd60);
      end

      set_cfg(cfg_b);
      run_scan("B", cfg_b, cfg_b, 1'b0, 0, 1'b0, 0);
      check("B line_done count", 64'(ld_seen.size()), 64'd3);
      if (ld_seen.size() == 3) begin
         check("B line_done 1st", 64'(ld_seen[0]), 64'd8);
         check("B line_done 2nd", 64'(ld_seen[1]), 64'd16);
         check("B line_done 3rd", 64'(ld_seen[2]), 64'd24);
      end
      check("B scan_done cycle", 64'(done_seen), 64'd25);

      set_cfg(cfg_bad);
      expect_reject("acq==P");

      // Abort at c=5 of point 3 (cycle 36), then hold abort with a start underneath it.
      set_cfg(cfg_a);
      run_scan("abort", cfg_a, cfg_a, 1'b0, 0, 1'b0, 36);
      check("abort no scan_done", 64'(done_seen), 64'd0);
      run_scan("rerun", cfg_a, cfg_a, 1'b0, 0, 1'b0, 0);
      check("rerun scan_done cycle", 64'(done_seen), 64'd61);

      run_scan("cfg in run", cfg_a, cfg_p20, 1'b0, 5, 1'b0, 0);
      run_scan("after ignored cfg", cfg_a, cfg_a, 1'b0, 0, 1'b0, 0);

      run_scan("cfg+start", cfg_a, cfg_b, 1'b1, 0, 1'b0, 0);
      run_scan("new cfg applies", cfg_b, cfg_b, 1'b0, 0, 1'b0, 0);

      set_cfg(cfg_p1);
      run_scan("P1", cfg_p1, cfg_p1, 1'b0, 0, 1'b0, 0);
      check("P1 scan_done cycle", 64'(done_seen), 64'd5);
      check("P1 line_done count", 64'(ld_seen.size()), 64'd1);
      if (ld_seen.size() == 1) check("P1 line_done cycle", 64'(ld_seen[0]), 64'd4);

      // Asynchronous reset in the middle of a scan.
      set_cfg(cfg_a);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (19) tick();
      check("busy before reset", obs() & BUSY_ONLY, BUSY_ONLY);
      rst_n = 1'b0;
      #1;
      check("async reset clears", obs(), 64'h0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      check("idle after release", obs(), 64'h0);
      expect_reject("shadow cleared by reset");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
